vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator for the 640x480@60 demo pipeline. Walks horizontal and vertical pixel counters and produces registered sync, blanking, line/frame strobes and a frame counter. Its `x` and `y[8:0]` feed the text and overlay stages directly. Its sync and `display_on` outputs go to the pin-out stage.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_ACTIVE_LOW`, 1, 1 = hsync/vsync driven low while asserted
- `FRAME_W`, 8, width of `frame_count`
- `clk` in 1: single clock; pixel rate is qualified by `ce`
- `reset` in 1: asynchronous, active-high
- `ce` in 1: pixel advance enable; tie to 1 when `clk` is the pixel clock
- `x` out 10: horizontal counter, 0..H_TOTAL-1
- `y` out 10: vertical counter, 0..V_TOTAL-1; downstream text stages use `y[8:0]`
- `display_on` out 1: high when x < H_DISPLAY and y < V_DISPLAY
- `hsync` out 1: horizontal sync, polarity per `SYNC_ACTIVE_LOW`
- `vsync` out 1: vertical sync, polarity per `SYNC_ACTIVE_LOW`
- `line_start` out 1: one-`clk` pulse on entering x = 0
- `frame_start` out 1: one-`clk` pulse on entering (x, y) = (0, 0)
- `frame_count` out FRAME_W: frames begun since reset, modulo 2^FRAME_W

## Operation
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525). Both must be ≤ 1024; the bench checks this with an elaboration-time assertion.
- Counter advance happens only on `clk` edges with `ce` = 1.
  - x increments. At x = H_TOTAL-1, x wraps to 0 and y advances.
  - y increments. At y = V_TOTAL-1, y wraps to 0 and `frame_count` increments, wrapping modulo 2^FRAME_W.
- hsync is asserted for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- vsync is asserted for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491, across all x of those lines.
- `ce` = 0 holds all counters and levels.
  - Strobes are high only in the single `clk` cycle immediately following the advancing edge. They never stretch while `ce` is low.
- Reset values, held for as long as `reset` is high:
  - x = H_TOTAL-1, y = V_TOTAL-1
  - `frame_count` = all ones
  - `display_on` = 0; hsync and vsync deasserted (pins high when active-low)
  - `line_start` = `frame_start` = 0
- Consequence: the first `ce` edge after reset enters (0, 0), pulses `line_start` and `frame_start`, and sets `frame_count` to 0. The first frame is therefore always complete and numbered 0.
- Reset mid-frame aborts immediately, with no wait for frame end.

## Timing
- All outputs are flops. `display_on`, hsync and vsync are computed from the next counter value, so they are cycle-aligned with the `x`/`y` they describe. Latency relative to `x`/`y` is 0.
- A stage consuming `x`/`y` combinationally sees sync and `display_on` for the same pixel in the same cycle.
- `frame_count` changes on the same edge at which `frame_start` rises.
- `line_start` and `frame_start` coincide at (0, 0).

## Structure
- Package `vga_timing_pkg`:
  - 640x480@60 timing constants: H/V display, porches, sync widths and totals.
  - Derived sync start/end localparams, so downstream overlay stages share the same numbers.
- Sub-module `vga_axis_counter` (params DISPLAY, FRONT, SYNC, BACK, WIDTH), instantiated twice:
  - Horizontal instance: `adv` = `ce`.
  - Vertical instance: `adv` = horizontal wrap.
  - Outputs `count`, `wrap`, `active`, `sync_on`. Reset loads TOTAL-1.
- Top level combines the two instances, applies polarity, generates strobes and holds `frame_count`.

## Test plan
- **Reset hold:** `reset` = 1 for 5 cycles, `ce` = 1 → x = 799, y = 524, `display_on` = 0, hsync = vsync = 1, `frame_count` = 8'hFF. First edge after release → x = 0, y = 0, `display_on` = 1, `line_start` = `frame_start` = 1 for one cycle, `frame_count` = 0.
- **Horizontal timing:** `ce` = 1, run one line → `display_on` falls at x = 640; hsync low exactly for x = 656..751 (96 cycles); `line_start` recurs every 800 cycles.
- **Vertical timing:** run one full frame → vsync low exactly for y = 490..491 (1600 cycles); `frame_start` period 420000 cycles; no `display_on` for y ≥ 480.
- **`ce` gating:** `ce` toggling 1,0,1,0 → x advances every 2 `clk`; strobes last one `clk` only; period in `clk` cycles doubles to 840000 per frame.
- **Frame counter wrap:** `FRAME_W` = 2, run 5 frames → `frame_count` sequence 0,1,2,3,0, each change coincident with `frame_start`.
- **Reset mid-frame:** assert `reset` at x = 300, y = 200 → outputs jump asynchronously to reset values within the cycle. Release → the next edge produces (0, 0) with `frame_start` = 1 and `frame_count` = 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 640x480@60 raster timing constants, derived sync windows and a
//            helper that maps an asserted sync flag onto the pin level.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Counter width shared by the x/y outputs and both axis counters
  localparam int c_CNT_W = 10;

  // Horizontal timing (pixels)
  localparam int c_H_DISPLAY = 640;
  localparam int c_H_FRONT   = 16;
  localparam int c_H_SYNC    = 96;
  localparam int c_H_BACK    = 48;
  localparam int c_H_TOTAL   = c_H_DISPLAY + c_H_FRONT + c_H_SYNC + c_H_BACK;

  // Vertical timing (lines)
  localparam int c_V_DISPLAY = 480;
  localparam int c_V_FRONT   = 10;
  localparam int c_V_SYNC    = 2;
  localparam int c_V_BACK    = 33;
  localparam int c_V_TOTAL   = c_V_DISPLAY + c_V_FRONT + c_V_SYNC + c_V_BACK;

  // Inclusive sync windows, shared with the overlay stages
  localparam int c_H_SYNC_START = c_H_DISPLAY + c_H_FRONT;
  localparam int c_H_SYNC_END   = c_H_SYNC_START + c_H_SYNC - 1;
  localparam int c_V_SYNC_START = c_V_DISPLAY + c_V_FRONT;
  localparam int c_V_SYNC_END   = c_V_SYNC_START + c_V_SYNC - 1;

  // Pin level for a sync flag: inverted when the board wants active-low sync
  function automatic logic sync_pin(input logic asserted, input logic active_low);
    return active_low ? ~asserted : asserted;
  endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Brief    : One raster axis. Counts 0..TOTAL-1 on each advance, reports the
//            wrap, and flags display/sync for the value being loaded so that
//            registered flags line up with the new count.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
  parameter int DISPLAY = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int WIDTH   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync_on
);

  localparam int             c_TOTAL      = DISPLAY + FRONT + SYNC + BACK;
  localparam logic [WIDTH-1:0] c_LAST       = WIDTH'(c_TOTAL - 1);
  localparam logic [WIDTH-1:0] c_DISP_END   = WIDTH'(DISPLAY);
  localparam logic [WIDTH-1:0] c_SYNC_FIRST = WIDTH'(DISPLAY + FRONT);
  localparam logic [WIDTH-1:0] c_SYNC_LAST  = WIDTH'(DISPLAY + FRONT + SYNC - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_at_last;

  // Next count: hold unless advancing, wrap to zero after the last position
  always_comb begin
    w_at_last   = (r_count == c_LAST);
    w_count_nxt = r_count;
    if (adv) begin
      w_count_nxt = w_at_last ? '0 : r_count + WIDTH'(1);
    end
  end

  // Counter register; reset parks on the last position so the first advance enters 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= c_LAST;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign count   = r_count;
  assign wrap    = adv & w_at_last;
  // Flags describe the value about to be loaded, so the parent can register
  // them on the same edge as the count and keep zero latency against it.
  assign active  = (w_count_nxt < c_DISP_END);
  assign sync_on = (w_count_nxt >= c_SYNC_FIRST) && (w_count_nxt <= c_SYNC_LAST);

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Brief    : Raster timing generator. Chains a horizontal and a vertical axis
//            counter and registers display enable, sync pins, line/frame
//            strobes and a free-running frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY       = c_H_DISPLAY,
  parameter int H_FRONT         = c_H_FRONT,
  parameter int H_SYNC          = c_H_SYNC,
  parameter int H_BACK          = c_H_BACK,
  parameter int V_DISPLAY       = c_V_DISPLAY,
  parameter int V_FRONT         = c_V_FRONT,
  parameter int V_SYNC          = c_V_SYNC,
  parameter int V_BACK          = c_V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int FRAME_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam logic c_ACTIVE_LOW = (SYNC_ACTIVE_LOW != 0);
  localparam logic c_SYNC_IDLE  = c_ACTIVE_LOW;

  logic [c_CNT_W-1:0] w_h_count;
  logic               w_h_wrap;
  logic               w_h_active;
  logic               w_h_sync_on;
  logic [c_CNT_W-1:0] w_v_count;
  logic               w_v_wrap;
  logic               w_v_active;
  logic               w_v_sync_on;

  logic               r_display_on;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_line_start;
  logic               r_frame_start;
  logic [FRAME_W-1:0] r_frame_count;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .WIDTH   (c_CNT_W)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .adv     (ce),
    .count   (w_h_count),
    .wrap    (w_h_wrap),
    .active  (w_h_active),
    .sync_on (w_h_sync_on)
  );

  // Vertical axis steps once per completed line
  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .WIDTH   (c_CNT_W)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .adv     (w_h_wrap),
    .count   (w_v_count),
    .wrap    (w_v_wrap),
    .active  (w_v_active),
    .sync_on (w_v_sync_on)
  );

  // Level outputs registered from the next-position flags (same edge as x/y)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_display_on <= 1'b0;
      r_hsync      <= c_SYNC_IDLE;
      r_vsync      <= c_SYNC_IDLE;
    end else begin
      r_display_on <= w_h_active & w_v_active;
      r_hsync      <= sync_pin(w_h_sync_on, c_ACTIVE_LOW);
      r_vsync      <= sync_pin(w_v_sync_on, c_ACTIVE_LOW);
    end
  end

  // Strobes follow the advancing edge only; frame counter steps with frame_start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '1;
    end else begin
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
      if (w_v_wrap) begin
        r_frame_count <= r_frame_count + FRAME_W'(1);
      end
    end
  end

  assign x           = w_h_count;
  assign y           = w_v_count;
  assign display_on  = r_display_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule : vga_sync_gen
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Brief    : Directed bench. Instance A uses full 640x480 timing for reset and
//            horizontal checks; instance B uses a shrunken raster (15x10,
//            FRAME_W=2) so whole frames, ce gating, counter wrap and mid-frame
//            reset fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  // Small raster for instance B: H 8+2+3+2 = 15, V 6+1+2+1 = 10, frame = 150
  localparam int c_BH_DISP = 8, c_BH_FP = 2, c_BH_SY = 3, c_BH_BP = 2;
  localparam int c_BV_DISP = 6, c_BV_FP = 1, c_BV_SY = 2, c_BV_BP = 1;
  localparam int c_B_HTOT = 15;
  localparam int c_B_VTOT = 10;
  localparam int c_B_FRAME = 150;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A signals
  logic       reset_a, ce_a;
  logic [9:0] x_a, y_a;
  logic       disp_a, hs_a, vs_a, ls_a, fs_a;
  logic [7:0] fc_a;

  // Instance B signals
  logic       reset_b, ce_b;
  logic [9:0] x_b, y_b;
  logic       disp_b, hs_b, vs_b, ls_b, fs_b;
  logic [1:0] fc_b;

  vga_sync_gen u_dut_a (
    .clk         (clk),
    .reset       (reset_a),
    .ce          (ce_a),
    .x           (x_a),
    .y           (y_a),
    .display_on  (disp_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .line_start  (ls_a),
    .frame_start (fs_a),
    .frame_count (fc_a)
  );

  vga_sync_gen #(
    .H_DISPLAY (c_BH_DISP), .H_FRONT (c_BH_FP), .H_SYNC (c_BH_SY), .H_BACK (c_BH_BP),
    .V_DISPLAY (c_BV_DISP), .V_FRONT (c_BV_FP), .V_SYNC (c_BV_SY), .V_BACK (c_BV_BP),
    .SYNC_ACTIVE_LOW (1), .FRAME_W (2)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset_b),
    .ce          (ce_b),
    .x           (x_b),
    .y           (y_b),
    .display_on  (disp_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .line_start  (ls_b),
    .frame_start (fs_b),
    .frame_count (fc_b)
  );

  // Raster totals must fit the 10-bit counters
  initial begin
    if ((640 + 16 + 96 + 48) > 1024 || (480 + 10 + 2 + 33) > 1024 ||
        c_B_HTOT > 1024 || c_B_VTOT > 1024) begin
      $display("FAIL total_fit: raster total exceeds 1024");
      $fatal(1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Measurement scratch
  int   disp_fall_x, hs_low, hs_first, hs_last, ls_hits, ls_x, ls_y, t_ls0, t_ls1;
  logic prev_disp;
  int   vs_low, disp_cnt, disp_late, fs_hits, bad_period, fc_stray, t_fs, ls_wide, ls_cnt;
  logic [1:0] prev_fc;
  logic prev_ls;
  int   fc_seq [5];
  int   exp_seq [5] = '{0, 1, 2, 3, 0};
  int   wait_n;

  initial begin
    reset_a = 1'b1; ce_a = 1'b1;
    reset_b = 1'b1; ce_b = 1'b1;

    // ---------------- A: reset hold ----------------
    repeat (5) @(negedge clk);
    check("a_rst_x",  x_a, 799);
    check("a_rst_y",  y_a, 524);
    check("a_rst_disp", disp_a, 0);
    check("a_rst_hs", hs_a, 1);
    check("a_rst_vs", vs_a, 1);
    check("a_rst_fc", fc_a, 8'hFF);
    check("a_rst_ls", ls_a, 0);
    check("a_rst_fs", fs_a, 0);

    reset_a = 1'b0;
    @(negedge clk);
    t_ls0 = cyc;
    check("a_first_x", x_a, 0);
    check("a_first_y", y_a, 0);
    check("a_first_disp", disp_a, 1);
    check("a_first_ls", ls_a, 1);
    check("a_first_fs", fs_a, 1);
    check("a_first_fc", fc_a, 0);
    @(negedge clk);
    check("a_ls_drop", ls_a, 0);
    check("a_fs_drop", fs_a, 0);
    check("a_x1", x_a, 1);

    // ---------------- A: one full line ----------------
    disp_fall_x = -1; hs_low = 0; hs_first = -1; hs_last = -1;
    ls_hits = 0; ls_x = -1; ls_y = -1; t_ls1 = 0;
    prev_disp = disp_a;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (prev_disp && !disp_a && disp_fall_x < 0) disp_fall_x = int'(x_a);
      prev_disp = disp_a;
      if (!hs_a) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x_a);
        hs_last = int'(x_a);
      end
      if (ls_a) begin
        ls_hits++; ls_x = int'(x_a); ls_y = int'(y_a); t_ls1 = cyc;
      end
    end
    check("a_disp_fall_x", disp_fall_x, 640);
    check("a_hs_low_cnt", hs_low, 96);
    check("a_hs_first", hs_first, 656);
    check("a_hs_last", hs_last, 751);
    check("a_ls_hits", ls_hits, 1);
    check("a_ls_x", ls_x, 0);
    check("a_ls_y", ls_y, 1);
    check("a_ls_period", t_ls1 - t_ls0, 800);

    // ---------------- B: reset and five frames ----------------
    check("b_rst_x", x_b, 14);
    check("b_rst_y", y_b, 9);
    check("b_rst_fc", fc_b, 3);
    check("b_rst_hs", hs_b, 1);
    reset_b = 1'b0;
    @(negedge clk);
    check("b_first_fs", fs_b, 1);
    check("b_first_fc", fc_b, 0);
    fc_seq[0] = int'(fc_b);
    t_fs = cyc; prev_fc = fc_b;
    vs_low = 0; hs_low = 0; disp_cnt = 0; disp_late = 0;
    fs_hits = 0; bad_period = 0; fc_stray = 0;
    for (int i = 1; i <= 4 * c_B_FRAME; i++) begin
      @(negedge clk);
      if (!vs_b) vs_low++;
      if (!hs_b) hs_low++;
      if (disp_b) disp_cnt++;
      if (disp_b && y_b >= 10'(c_BV_DISP)) disp_late++;
      if (fc_b != prev_fc && !fs_b) fc_stray++;
      prev_fc = fc_b;
      if (fs_b) begin
        fs_hits++;
        if (fs_hits < 5) fc_seq[fs_hits] = int'(fc_b);
        if (cyc - t_fs != c_B_FRAME) bad_period++;
        t_fs = cyc;
      end
    end
    check("b_vs_low_cnt", vs_low, 4 * 30);
    check("b_hs_low_cnt", hs_low, 4 * 10 * 3);
    check("b_disp_cnt", disp_cnt, 4 * 48);
    check("b_disp_late", disp_late, 0);
    check("b_fs_hits", fs_hits, 4);
    check("b_fs_period", bad_period, 0);
    check("b_fc_stray", fc_stray, 0);
    for (int k = 0; k < 5; k++) check($sformatf("b_fc_seq%0d", k), fc_seq[k], exp_seq[k]);

    // ---------------- B: ce toggling 0,1,0,1 ----------------
    ce_b = 1'b0;
    fs_hits = 0; bad_period = 0; ls_wide = 0; ls_cnt = 0;
    t_fs = cyc; prev_ls = ls_b;
    for (int i = 1; i <= 4 * c_B_FRAME; i++) begin
      @(negedge clk);
      if (i == 7) check("b_ce_x_i7", x_b, 3);
      if (i == 8) check("b_ce_x_i8", x_b, 4);
      if (ls_b) ls_cnt++;
      if (ls_b && prev_ls) ls_wide++;
      prev_ls = ls_b;
      if (fs_b) begin
        fs_hits++;
        if (cyc - t_fs != 2 * c_B_FRAME) bad_period++;
        t_fs = cyc;
      end
      ce_b = (i % 2 == 1);
    end
    check("b_ce_fs_hits", fs_hits, 2);
    check("b_ce_fs_period", bad_period, 0);
    check("b_ce_ls_cnt", ls_cnt, 20);
    check("b_ce_ls_wide", ls_wide, 0);
    check("b_ce_fc", fc_b, 2);
    ce_b = 1'b1;

    // ---------------- B: reset mid-frame ----------------
    wait_n = 0;
    while (!(x_b == 10'd5 && y_b == 10'd3) && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    check("b_wait_pos", (wait_n < 400), 1);
    check("b_mid_disp", disp_b, 1);
    #2 reset_b = 1'b1;
    #1;
    check("b_async_x", x_b, 14);
    check("b_async_y", y_b, 9);
    check("b_async_disp", disp_b, 0);
    check("b_async_fc", fc_b, 3);
    @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    check("b_rel_x", x_b, 0);
    check("b_rel_y", y_b, 0);
    check("b_rel_fs", fs_b, 1);
    check("b_rel_ls", ls_b, 1);
    check("b_rel_fc", fc_b, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_vga_sync_gen
`default_nettype wire
